// File: rtl/dram_responder.sv
// rtl/dram_responder.sv - single-port DRAM request responder with region-clear engine; optional parity via DRAM_PARITY_EN
module dram_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_clr_start,
  input  logic [ADDR_WIDTH-1:0] i_clr_base,
  input  logic [ADDR_WIDTH:0]   i_clr_len,
  output logic                  o_clr_busy,
  output logic                  o_clr_done,
  output logic                  o_req_drop,
  input  logic                  i_inject_par,
  output logic                  o_parity_err,
  output logic [31:0]           o_rd_count,
  output logic [31:0]           o_wr_count
);

  localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   L_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   L_ZERO = 0;

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic [ADDR_WIDTH:0]   r_clr_rem;

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  logic [RD_LATENCY-1:0] r_pv;
  logic [DATA_WIDTH-1:0] r_pd [RD_LATENCY];

  logic                  w_clearing;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_bypass;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_data;

  // Requests are only refused while the clear engine owns the write port
  assign w_clearing = (r_state == ST_CLEAR);
  assign w_rd_acc   = i_rd_en & ~w_clearing;
  assign w_wr_acc   = i_wr_en & ~w_clearing;
  assign w_bypass   = w_wr_acc & (i_wr_addr == i_rd_addr);
  assign w_rd_word  = w_bypass ? i_wr_data : r_mem[i_rd_addr];

  // Writes are gated by reset so an aborted clear stops on the reset edge
  assign w_mem_we   = srstn & (w_clearing | w_wr_acc);
  assign w_mem_addr = w_clearing ? r_clr_addr : i_wr_addr;
  assign w_mem_data = w_clearing ? '0 : i_wr_data;

  assign o_rd_valid = r_pv[RD_LATENCY-1];
  assign o_rd_data  = r_pd[RD_LATENCY-1];

  // Backing store write port, shared between layer writes and the clear engine
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
  end

  // Read pipeline: each stage only loads on valid so rd_data holds between strobes
  always_ff @(posedge clk) begin
    if (!srstn) begin
      r_pv <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_pd[i] <= '0;
    end else begin
      r_pv[0] <= w_rd_acc;
      if (w_rd_acc) r_pd[0] <= w_rd_word;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        if (r_pv[i-1]) r_pd[i] <= r_pd[i-1];
      end
    end
  end

  // Clear FSM with registered busy/done, plus sticky drop flag and counters
  always_ff @(posedge clk) begin
    if (!srstn) begin
      r_state    <= ST_IDLE;
      r_clr_addr <= '0;
      r_clr_rem  <= '0;
      o_clr_busy <= 1'b0;
      o_clr_done <= 1'b0;
      o_req_drop <= 1'b0;
      o_rd_count <= '0;
      o_wr_count <= '0;
    end else begin
      o_clr_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_clr_start) begin
            if (i_clr_len != L_ZERO) begin
              r_clr_addr <= i_clr_base;
              r_clr_rem  <= i_clr_len;
              o_clr_busy <= 1'b1;
              r_state    <= ST_CLEAR;
            end else begin
              o_clr_done <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          r_clr_addr <= r_clr_addr + A_ONE;
          r_clr_rem  <= r_clr_rem - L_ONE;
          if (r_clr_rem == L_ONE) begin
            o_clr_busy <= 1'b0;
            o_clr_done <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_clearing && (i_rd_en || i_wr_en)) o_req_drop <= 1'b1;
      if (w_rd_acc && o_rd_count != '1) o_rd_count <= o_rd_count + 32'd1;
      if (w_wr_acc && o_wr_count != '1) o_wr_count <= o_wr_count + 32'd1;
    end
  end

`ifdef DRAM_PARITY_EN
  logic                  r_par [2**ADDR_WIDTH];
  logic [RD_LATENCY-1:0] r_pp;
  logic                  r_perr;
  logic                  w_wr_par;
  logic                  w_rd_par;
  logic                  w_mis;

  assign w_wr_par = (^i_wr_data) ^ i_inject_par;
  assign w_rd_par = w_bypass ? w_wr_par : r_par[i_rd_addr];
  assign w_mis    = o_rd_valid & ((^o_rd_data) != r_pp[RD_LATENCY-1]);
  assign o_parity_err = r_perr | w_mis;

  // Parity store mirrors the data store; cleared words get parity 0
  always_ff @(posedge clk) begin
    if (w_mem_we) r_par[w_mem_addr] <= w_clearing ? 1'b0 : w_wr_par;
  end

  // Parity bit travels with its read data; mismatch is made sticky
  always_ff @(posedge clk) begin
    if (!srstn) begin
      r_pp   <= '0;
      r_perr <= 1'b0;
    end else begin
      r_pp[0] <= w_rd_acc ? w_rd_par : r_pp[0];
      for (int i = 1; i < RD_LATENCY; i++) begin
        if (r_pv[i-1]) r_pp[i] <= r_pp[i-1];
      end
      if (w_mis) r_perr <= 1'b1;
    end
  end
`else
  logic w_unused_inject;
  assign w_unused_inject = i_inject_par;
  assign o_parity_err    = 1'b0;
`endif

endmodule

// File: tb/tb_dram_responder.sv
// tb/tb_dram_responder.sv - directed table-driven bench for dram_responder (latency 1 and 3 instances)
module tb_dram_responder;

  logic        clk = 1'b0;
  logic        srstn = 1'b0;
  logic        rd_en = 1'b0;
  logic [17:0] rd_addr = '0;
  logic        wr_en = 1'b0;
  logic [17:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        clr_start = 1'b0;
  logic [17:0] clr_base = '0;
  logic [18:0] clr_len = '0;
  logic        inject_par = 1'b0;

  logic [31:0] rd_data1, rd_data3, rd_count1, rd_count3, wr_count1, wr_count3;
  logic        rd_valid1, rd_valid3, clr_busy1, clr_busy3, clr_done1, clr_done3;
  logic        req_drop1, req_drop3, parity_err1, parity_err3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dram_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(18), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .srstn(srstn),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data1), .o_rd_valid(rd_valid1),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_clr_start(clr_start), .i_clr_base(clr_base), .i_clr_len(clr_len),
    .o_clr_busy(clr_busy1), .o_clr_done(clr_done1), .o_req_drop(req_drop1),
    .i_inject_par(inject_par), .o_parity_err(parity_err1),
    .o_rd_count(rd_count1), .o_wr_count(wr_count1)
  );

  dram_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(18), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .srstn(srstn),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data3), .o_rd_valid(rd_valid3),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_clr_start(clr_start), .i_clr_base(clr_base), .i_clr_len(clr_len),
    .o_clr_busy(clr_busy3), .o_clr_done(clr_done3), .o_req_drop(req_drop3),
    .i_inject_par(inject_par), .o_parity_err(parity_err3),
    .o_rd_count(rd_count3), .o_wr_count(wr_count3)
  );

  typedef struct {
    logic        rd;
    logic [17:0] ra;
    logic        wr;
    logic [17:0] wa;
    logic [31:0] wd;
    logic        ev;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = 1'b0; wr_en = 1'b0; clr_start = 1'b0; inject_par = 1'b0;
  endtask

  task automatic wr(input logic [17:0] a, input logic [31:0] d);
    rd_en = 1'b0; wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [17:0] a, input logic [31:0] d);
    rd_en = 1'b1; rd_addr = a;
    step();
    rd_en = 1'b0;
    chk({nm, "_valid"}, {63'd0, rd_valid1}, 64'd1);
    chk({nm, "_data"}, {32'd0, rd_data1}, {32'd0, d});
  endtask

  initial begin
    int busy_cnt, done_cnt, vld_cnt;
    logic [31:0] rc_before;

    vecs[0] = '{1'b0, 18'h0,     1'b1, 18'h20000, 32'h0001_0000, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 18'h20000, 1'b0, 18'h0,     32'h0,         1'b1, 32'h0001_0000};
    vecs[2] = '{1'b1, 18'h10005, 1'b1, 18'h10005, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 18'h0,     1'b1, 18'h20010, 32'd5,         1'b0, 32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 18'h20010, 1'b0, 18'h0,     32'h0,         1'b1, 32'd5};
    vecs[5] = '{1'b0, 18'h0,     1'b1, 18'h20010, 32'd8,         1'b0, 32'd5};
    vecs[6] = '{1'b1, 18'h20010, 1'b0, 18'h0,     32'h0,         1'b1, 32'd8};
    vecs[7] = '{1'b1, 18'h20010, 1'b1, 18'h20011, 32'd7,         1'b1, 32'd8};
    vecs[8] = '{1'b1, 18'h20011, 1'b0, 18'h0,     32'h0,         1'b1, 32'd7};
    vecs[9] = '{1'b0, 18'h0,     1'b0, 18'h0,     32'h0,         1'b0, 32'd7};

    // reset state
    srstn = 1'b0;
    step(); step();
    srstn = 1'b1;
    chk("rst_rd_valid", {63'd0, rd_valid1}, 64'd0);
    chk("rst_rd_data", {32'd0, rd_data1}, 64'd0);
    chk("rst_busy", {63'd0, clr_busy1}, 64'd0);
    chk("rst_done", {63'd0, clr_done1}, 64'd0);
    chk("rst_drop", {63'd0, req_drop1}, 64'd0);
    chk("rst_rd_count", {32'd0, rd_count1}, 64'd0);
    chk("rst_wr_count", {32'd0, wr_count1}, 64'd0);

    // table-driven read/write vectors, latency 1
    for (int i = 0; i < 10; i++) begin
      rd_en = vecs[i].rd; rd_addr = vecs[i].ra;
      wr_en = vecs[i].wr; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      step();
      chk($sformatf("vec%0d_valid", i), {63'd0, rd_valid1}, {63'd0, vecs[i].ev});
      chk($sformatf("vec%0d_data", i), {32'd0, rd_data1}, {32'd0, vecs[i].ed});
    end
    idle();
    chk("tbl_rd_count", {32'd0, rd_count1}, 64'd6);
    chk("tbl_wr_count", {32'd0, wr_count1}, 64'd5);
    chk("tbl_rd_count3", {32'd0, rd_count3}, 64'd6);

    // latency 3: five back-to-back reads
    for (int i = 0; i < 5; i++) wr(18'h100 + 18'(i), 32'hA0 + 32'(i));
    for (int c = 0; c < 10; c++) begin
      rd_en = (c < 5); rd_addr = 18'h100 + 18'(c);
      step();
      chk($sformatf("lat3_valid_c%0d", c), {63'd0, rd_valid3}, {63'd0, (c >= 2 && c <= 6)});
      if (c >= 2 && c <= 6)
        chk($sformatf("lat3_data_c%0d", c), {32'd0, rd_data3}, {32'd0, 32'hA0 + 32'(c - 2)});
      chk($sformatf("lat1_valid_c%0d", c), {63'd0, rd_valid1}, {63'd0, (c < 5)});
    end
    idle();

    // region clear across the address wrap
    wr(18'h3FFFE, 32'hFFFF_FFFF);
    wr(18'h3FFFF, 32'hFFFF_FFFF);
    wr(18'h00000, 32'hFFFF_FFFF);
    wr(18'h00001, 32'hFFFF_FFFF);
    wr(18'h00002, 32'h55);
    rc_before = rd_count1;
    clr_start = 1'b1; clr_base = 18'h3FFFE; clr_len = 19'd4;
    step();
    clr_start = 1'b0;
    busy_cnt = 0; done_cnt = 0; vld_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (clr_busy1) busy_cnt++;
      if (clr_done1) done_cnt++;
      if (rd_valid1) vld_cnt++;
      rd_en = (c == 0); rd_addr = 18'h2;
      clr_start = (c == 1); clr_len = 19'd0;
      step();
    end
    idle();
    chk("clr_busy_cycles", 64'(busy_cnt), 64'd4);
    chk("clr_done_pulses", 64'(done_cnt), 64'd1);
    chk("clr_no_rd_valid", 64'(vld_cnt), 64'd0);
    chk("clr_req_drop", {63'd0, req_drop1}, 64'd1);
    chk("clr_rd_count", {32'd0, rd_count1}, {32'd0, rc_before});
    rd_chk("clr_3fffe", 18'h3FFFE, 32'h0);
    rd_chk("clr_3ffff", 18'h3FFFF, 32'h0);
    rd_chk("clr_00000", 18'h00000, 32'h0);
    rd_chk("clr_00001", 18'h00001, 32'h0);
    rd_chk("clr_00002", 18'h00002, 32'h55);

    // zero-length clear: immediate done pulse, never busy
    clr_start = 1'b1; clr_len = 19'd0;
    step();
    clr_start = 1'b0;
    chk("len0_done", {63'd0, clr_done1}, 64'd1);
    chk("len0_busy", {63'd0, clr_busy1}, 64'd0);
    step();
    chk("len0_done_off", {63'd0, clr_done1}, 64'd0);

`ifdef DRAM_PARITY_EN
    inject_par = 1'b1; wr(18'h300, 32'h1); inject_par = 1'b0;
    wr(18'h301, 32'h3);
    rd_chk("par_ok", 18'h301, 32'h3);
    chk("par_ok_err", {63'd0, parity_err1}, 64'd0);
    rd_chk("par_bad", 18'h300, 32'h1);
    chk("par_bad_err", {63'd0, parity_err1}, 64'd1);
`else
    chk("par_tied0", {63'd0, parity_err1}, 64'd0);
`endif

    // reset in the middle of an 8-word clear
    for (int i = 0; i < 8; i++) wr(18'h200 + 18'(i), 32'hFF);
    clr_start = 1'b1; clr_base = 18'h200; clr_len = 19'd8;
    step();
    clr_start = 1'b0;
    step(); step();
    chk("mid_busy_before", {63'd0, clr_busy1}, 64'd1);
    srstn = 1'b0;
    step();
    srstn = 1'b1;
    chk("mid_busy", {63'd0, clr_busy1}, 64'd0);
    chk("mid_done", {63'd0, clr_done1}, 64'd0);
    chk("mid_drop", {63'd0, req_drop1}, 64'd0);
    chk("mid_perr", {63'd0, parity_err1}, 64'd0);
    chk("mid_rd_valid", {63'd0, rd_valid1}, 64'd0);
    chk("mid_rd_data", {32'd0, rd_data1}, 64'd0);
    chk("mid_rd_count", {32'd0, rd_count1}, 64'd0);
    chk("mid_wr_count", {32'd0, wr_count1}, 64'd0);
    done_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (clr_done1) done_cnt++;
      if (clr_busy1) busy_cnt++;
      step();
    end
    chk("mid_no_done", 64'(done_cnt), 64'd0);
    chk("mid_no_busy", 64'(busy_cnt), 64'd0);
    rd_chk("mid_w0", 18'h200, 32'h0);
    rd_chk("mid_w1", 18'h201, 32'h0);
    rd_chk("mid_w2", 18'h202, 32'hFF);
    rd_chk("mid_w7", 18'h207, 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
